// File: rtl/norm_pkg.sv
// Shared definitions for the leading-one normalizer: controller states and
// the default operand / shift-count widths.
package norm_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;  // clog2(WIDTH+1): must be able to hold WIDTH itself

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/norm_shift_reg.sv
// Loadable left-shift register. A load takes priority over a shift.
module norm_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_left,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Register update: load wins, otherwise shift in a zero from the right.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= data_in;
    end else if (shift_left) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/leading_one_normalizer.sv
// Leading-one normalizer: shifts the operand left until its MSB is set and
// reports the number of shifts taken, with a start/busy/done handshake.
// A zero operand short-circuits straight to DONE with a count of WIDTH.
module leading_one_normalizer #(
  parameter int WIDTH = norm_pkg::WIDTH,
  parameter int CNT_W = norm_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] norm_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             zero_flag
);

  import norm_pkg::*;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_load;
  logic             w_shift;
  logic             w_msb;
  logic             w_operand_zero;
  logic [WIDTH-1:0] w_reg_q;

  // start is only honoured while idle; anything else is dropped, not queued.
  assign w_accept       = (r_state == IDLE) && start;
  assign w_operand_zero = (data_in == '0);
  assign w_msb          = w_reg_q[WIDTH-1];
  assign w_load         = w_accept;
  assign w_shift        = (r_state == SHIFT) && !w_msb;

  norm_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_load),
    .shift_left (w_shift),
    .data_in    (data_in),
    .q          (w_reg_q)
  );

  // Controller: state, shift counter, zero flag and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (w_operand_zero) begin
              r_cnt   <= CNT_W'(WIDTH);
              r_zero  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt   <= '0;
              r_zero  <= 1'b0;
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (w_msb) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            // Bounded by WIDTH-1 for a nonzero operand, so no wrap.
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign norm_out  = w_reg_q;
  assign shift_cnt = r_cnt;
  assign zero_flag = r_zero;

endmodule

// File: tb/tb_leading_one_normalizer.sv
// Self-checking bench for leading_one_normalizer: a driver pushes expected
// results into a scoreboard queue; a monitor pops and compares on each done.
module tb_leading_one_normalizer;

  localparam int W  = 16;
  localparam int CW = 5;

  typedef struct {
    logic [W-1:0]  norm;
    logic [CW-1:0] cnt;
    logic          zero;
    int            done_cyc;
    int            busy_len;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  data_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  norm_out;
  logic [CW-1:0] shift_cnt;
  logic          zero_flag;

  int   n_checks;
  int   n_errors;
  int   cyc;
  int   busy_run;
  logic prev_done;
  exp_t sb_q[$];
  exp_t last_exp;

  leading_one_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .norm_out  (norm_out),
    .shift_cnt (shift_cnt),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: locate the leading one by scanning from the MSB down.
  function automatic exp_t model(input logic [W-1:0] d, input int drive_cyc);
    exp_t e;
    int   k;
    k = -1;
    for (int i = W - 1; i >= 0; i--) begin
      if (k < 0 && d[i]) k = W - 1 - i;
    end
    if (k < 0) begin
      e.norm     = '0;
      e.cnt      = CW'(W);
      e.zero     = 1'b1;
      e.done_cyc = drive_cyc + 1;
    end else begin
      e.norm     = d << k;
      e.cnt      = CW'(k);
      e.zero     = 1'b0;
      e.done_cyc = drive_cyc + k + 2;
    end
    e.busy_len = e.done_cyc - drive_cyc;
    return e;
  endfunction

  // Monitor: compare results when done shows, plus handshake shape.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      busy_run = busy ? busy_run + 1 : 0;
      if (prev_done) begin
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("norm_out", {16'd0, norm_out}, {16'd0, e.norm});
          check("shift_cnt", {27'd0, shift_cnt}, {27'd0, e.cnt});
          check("zero_flag", {31'd0, zero_flag}, {31'd0, e.zero});
          check("done_latency", cyc, e.done_cyc);
          check("busy_length", busy_run, e.busy_len);
        end
      end
      prev_done = done;
    end
  end

  task automatic run_op(input logic [W-1:0] d);
    @(negedge clk);
    start   = 1'b1;
    data_in = d;
    last_exp = model(d, cyc);
    sb_q.push_back(last_exp);
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'hDEAD;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, 32'd1, 32'd0);
    // Results must hold in IDLE after the operation completes.
    repeat (2) @(negedge clk);
    check({tag, "_hold_norm"}, {16'd0, norm_out}, {16'd0, last_exp.norm});
    check({tag, "_hold_cnt"}, {27'd0, shift_cnt}, {27'd0, last_exp.cnt});
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    busy_run  = 0;
    prev_done = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    data_in   = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_norm", {16'd0, norm_out}, 32'd0);
    check("rst_cnt", {27'd0, shift_cnt}, 32'd0);
    check("rst_zero", {31'd0, zero_flag}, 32'd0);
    rst_n = 1'b1;

    run_op(16'h8000); drain("op8000");
    run_op(16'h00F0); drain("op00F0");
    run_op(16'h0001); drain("op0001");
    run_op(16'h0000); drain("op0000");
    run_op(16'h2A5C); drain("op2A5C");

    // start re-pulsed during SHIFT must be ignored.
    run_op(16'h0010);
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'h1234;
    @(negedge clk);
    start   = 1'b0;
    drain("ignore");

    // start held high through DONE: accepted again on the first IDLE cycle.
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'h4000;
    sb_q.push_back(model(16'h4000, cyc));
    last_exp = model(16'h4000, cyc + 4);
    sb_q.push_back(last_exp);
    repeat (5) @(negedge clk);
    start = 1'b0;
    drain("b2b");

    // Asynchronous reset in the middle of SHIFT abandons the operation.
    run_op(16'h0003);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_norm", {16'd0, norm_out}, 32'd0);
    check("midrst_cnt", {27'd0, shift_cnt}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h4000); drain("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
